array_pack_stage: RTL and testbench
===================================

// Module: array_pack_stage
// PURPOSE
//   Downstream consumer of the constant-array comb stage: accepts its narrow
//   IN_W-bit array output one beat per cycle under valid/ready and packs
//   OUT_W/IN_W consecutive beats, LSB-first, into one OUT_W-bit word.
//   Sits between the narrow array producer and wide word consumers; has a
//   one-word output register so packing continues while a word awaits drain.
// PARAMETERS
//   IN_W   2  width of one input beat (matches producer array width)
//   OUT_W  8  packed output width; must be an integer multiple of IN_W, >= 2*IN_W
// PORTS
//   CLK      in   1      clock, all state updates on rising edge
//   RESETN   in   1      synchronous active-low reset
//   I        in   IN_W   input beat
//   I_valid  in   1      beat valid
//   I_ready  out  1      stage can accept beat this cycle
//   O        out  OUT_W  packed word (registered)
//   O_valid  out  1      O holds an undelivered word
//   O_ready  in   1      consumer accepts O this cycle
// BEHAVIOUR
//   - N = OUT_W/IN_W beats per word; cnt is a clog2(N)-bit beat counter.
//   - Reset (RESETN==0 at CLK edge): cnt=0, acc=0, O=0, O_valid=0; any partial
//     word is discarded; I_ready is combinational and reads 1 while O_valid=0.
//   - Accept when I_valid && I_ready. Accepted beat k (k=cnt) lands in
//     acc[k*IN_W +: IN_W]; cnt increments.
//   - Final beat (cnt==N-1) accepted: O <= {I, acc[(N-1)*IN_W-1:0]},
//     O_valid <= 1, cnt <= 0, acc <= 0. O_valid rises the cycle after the last beat.
//   - Drain: O_valid && O_ready clears O_valid next cycle (O keeps its value) unless
//     a new word loads the same cycle, in which case O_valid stays 1 with new O.
//   - I_ready = !(cnt==N-1 && O_valid && !O_ready): beats 0..N-2 are always
//     accepted; only the completing beat stalls on a full, non-draining output.
//   - Throughput: sustained one word per N cycles with O_ready held high; no bubbles.
//   - I is ignored when I_valid=0; O_ready ignored when O_valid=0.
//   - Reset mid-word or with O_valid=1: state cleared next edge, word lost; no
//     O_valid pulse is produced from pre-reset beats.
//   - Invalid parameters (OUT_W % IN_W != 0 or N < 2): elaboration error.
// CONFIGURATION
//   ARRAY_PACK_PARITY_EN defined: adds output O_parity (1 bit) = ^O, registered
//     with O; reset 0; stable whenever O is stable.
//   Not defined: no O_parity port; no parity logic.
// TESTING
//   1 Reset, then beats 2'b11 x4 back-to-back, O_ready=1 -> O=8'hFF, O_valid
//     high exactly one cycle, 1 cycle after 4th beat.
//   2 Beats 2'b01,2'b10,2'b11,2'b00 -> O=8'h39 (parity 0 when _EN).
//   3 O_ready=0, feed 8 beats of 2'b01 -> first O=8'h55 held; beats 5-7 accepted,
//     I_ready=0 on beat 8 until O_ready=1; then second O=8'h55, no word lost.
//   4 Continuous beats with O_ready=1 for 40 cycles -> 10 words, O_valid every 4th cycle.
//   5 2 beats of 2'b11, RESETN=0 one cycle, then 2'b00 x4 -> O=8'h00 (no stale bits).
//   6 I_valid toggling every other cycle, beats 2'b10 x4 -> O=8'hAA after 8 cycles;
//     with ARRAY_PACK_PARITY_EN, beats 01,00,00,00 -> O=8'h01, O_parity=1.

Source files
------------

// File: rtl/array_pack_stage_if.sv
// Narrow-beat in / wide-word out handshake bundle for array_pack_stage.
// master: the side that feeds beats and drains words (producer/consumer pair).
// slave:  the packing stage itself.
// ARRAY_PACK_PARITY_EN adds the registered O_parity signal.
interface array_pack_stage_if #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 8
);
  logic [IN_W-1:0]  I;
  logic             I_valid;
  logic             I_ready;
  logic [OUT_W-1:0] O;
  logic             O_valid;
  logic             O_ready;
`ifdef ARRAY_PACK_PARITY_EN
  logic             O_parity;

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, O_parity
  );

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, O_parity
  );
`else
  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid
  );

  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid
  );
`endif
endinterface

// File: rtl/array_pack_stage.sv
// array_pack_stage: packs OUT_W/IN_W consecutive IN_W-bit beats, LSB-first, into one
// OUT_W-bit word held in a single output register. Packing of the next word proceeds
// while a finished word waits; only the completing beat stalls on a full output.
// Optional feature macro: ARRAY_PACK_PARITY_EN (adds registered O_parity = ^O).
module array_pack_stage #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 8
) (
  input logic               CLK,
  input logic               RESETN,
  array_pack_stage_if.slave bus
);

  localparam int unsigned N  = OUT_W / IN_W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  // Accumulator only needs the first N-1 beats; the last beat goes straight to O.
  localparam int unsigned AW = (N > 1) ? (N - 1) * IN_W : IN_W;

  if ((OUT_W % IN_W) != 0 || N < 2) begin : g_bad_params
    $error("array_pack_stage: OUT_W must be a multiple of IN_W and at least 2*IN_W");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic             o_valid_q, o_valid_d;

  logic last_beat;
  logic i_ready;
  logic accept;
  logic drain;

  // Handshake decode: only the word-completing beat can be back-pressured.
  always_comb begin
    last_beat = (cnt_q == CW'(N - 1));
    i_ready   = !(last_beat && o_valid_q && !bus.O_ready);
    accept    = bus.I_valid && i_ready;
    drain     = o_valid_q && bus.O_ready;
  end

  // Next-state: accumulate beats, hand the completed word to the output register.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;

    if (drain) begin
      o_valid_d = 1'b0;
    end

    if (accept) begin
      if (last_beat) begin
        o_d       = {bus.I, acc_q};
        o_valid_d = 1'b1;
        cnt_d     = '0;
        acc_d     = '0;
      end else begin
        for (int unsigned b = 0; b < N - 1; b++) begin
          if (cnt_q == CW'(b)) begin
            acc_d[b*IN_W +: IN_W] = bus.I;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset; partial words are dropped.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.I_ready = i_ready;
  assign bus.O       = o_q;
  assign bus.O_valid = o_valid_q;

`ifdef ARRAY_PACK_PARITY_EN
  logic parity_q;

  // Parity tracks o_d so it changes only in the same cycle O does.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^o_d;
    end
  end

  assign bus.O_parity = parity_q;
`endif

endmodule

// File: tb/tb_array_pack_stage.sv
// Bench for array_pack_stage: directed table, multi-cycle sequences and random traffic
// checked against a queue-based reference model.
module tb_array_pack_stage;

  localparam int unsigned IN_W  = 2;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned N     = OUT_W / IN_W;

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;

  array_pack_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  array_pack_stage #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_words = 0;

  // Reference model: pending beats of the current word and the output slot.
  int unsigned      m_beats[$];
  bit               m_pend = 1'b0;
  logic [OUT_W-1:0] m_word = '0;

  // Values seen during the most recent step, before its clock edge.
  logic             s_ir;
  logic             s_ov;
  logic [OUT_W-1:0] s_o;
  logic             s_par;

  typedef struct {
    logic             v;
    logic [IN_W-1:0]  i;
    logic             ordy;
    logic             e_ir;
    logic             e_ov;
    logic [OUT_W-1:0] e_o;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] pack_beats();
    logic [OUT_W-1:0] w = '0;
    for (int k = 0; k < m_beats.size(); k++) begin
      w = w + OUT_W'(m_beats[k] * (32'd1 << (IN_W * k)));
    end
    return w;
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic rstn, input logic v, input logic [IN_W-1:0] beat,
                      input logic ordy);
    logic exp_ir;
    @(negedge CLK);
    RESETN      = rstn;
    bus.I_valid = v;
    bus.I       = beat;
    bus.O_ready = ordy;
    #1;
    exp_ir = !(m_beats.size() == N - 1 && m_pend && !ordy);
    s_ir = bus.I_ready;
    s_ov = bus.O_valid;
    s_o  = bus.O;
    chk("model_i_ready", 32'(s_ir), 32'(exp_ir));
    chk("model_o_valid", 32'(s_ov), 32'(m_pend));
    chk("model_o", 32'(s_o), 32'(m_word));
`ifdef ARRAY_PACK_PARITY_EN
    s_par = bus.O_parity;
    chk("model_parity", 32'(s_par), 32'(^m_word));
`else
    s_par = 1'b0;
`endif
    if (rstn && s_ov && ordy) obs_words++;
    @(posedge CLK);
    if (!rstn) begin
      m_beats.delete();
      m_pend = 1'b0;
      m_word = '0;
    end else begin
      if (m_pend && ordy) m_pend = 1'b0;
      if (v && exp_ir) begin
        m_beats.push_back(int'(beat));
        if (m_beats.size() == N) begin
          m_word = pack_beats();
          m_pend = 1'b1;
          m_beats.delete();
        end
      end
    end
  endtask

  initial begin
    int w0;

    // Words 8'hFF then 8'h39, O_ready held high.
    tbl[0] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'hFF};
    tbl[5] = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[6] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[7] = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h39};
    tbl[9] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'h39};

    bus.I_valid = 1'b0;
    bus.I       = '0;
    bus.O_ready = 1'b0;
    RESETN      = 1'b0;
    repeat (2) @(posedge CLK);

    // Tests 1 and 2 (first row also covers the reset state).
    for (int k = 0; k < 10; k++) begin
      step(1'b1, tbl[k].v, tbl[k].i, tbl[k].ordy);
      chk($sformatf("tbl%0d_i_ready", k), 32'(s_ir), 32'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_o_valid", k), 32'(s_ov), 32'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_o", k), 32'(s_o), 32'(tbl[k].e_o));
`ifdef ARRAY_PACK_PARITY_EN
      chk($sformatf("tbl%0d_parity", k), 32'(s_par), 32'(^tbl[k].e_o));
`endif
    end

    // Test 3: output blocked, second word completes only once O_ready rises.
    w0 = obs_words;
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 2'b01, 1'b0);
      chk("t3_stall_i_ready", 32'(s_ir), 32'd0);
      chk("t3_held_o", 32'(s_o), 32'h55);
      chk("t3_held_o_valid", 32'(s_ov), 32'd1);
    end
    step(1'b1, 1'b1, 2'b01, 1'b1);
    chk("t3_release_i_ready", 32'(s_ir), 32'd1);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    chk("t3_second_o_valid", 32'(s_ov), 32'd1);
    chk("t3_second_o", 32'(s_o), 32'h55);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    chk("t3_drained", 32'(s_ov), 32'd0);
    chk("t3_word_count", 32'(obs_words - w0), 32'd2);

    // Test 4: 40 continuous beats -> a word every 4th cycle, 10 in all.
    w0 = obs_words;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b1, IN_W'($urandom_range(0, 3)), 1'b1);
      chk($sformatf("t4_o_valid_c%0d", k), 32'(s_ov), 32'((k % 4 == 0) && (k > 0)));
    end
    step(1'b1, 1'b0, 2'b00, 1'b1);
    chk("t4_word_count", 32'(obs_words - w0), 32'd10);

    // Test 5: reset mid-word discards the partial beats.
    step(1'b1, 1'b1, 2'b11, 1'b1);
    step(1'b1, 1'b1, 2'b11, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 2'b00, 1'b1);
      chk("t5_no_stale_valid", 32'(s_ov), 32'd0);
    end
    step(1'b1, 1'b0, 2'b00, 1'b1);
    chk("t5_o_valid", 32'(s_ov), 32'd1);
    chk("t5_o", 32'(s_o), 32'h00);

    // Test 6: I_valid toggling, beats 2'b10 -> 8'hAA.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'((k % 2) == 0), 2'b10, 1'b1);
      if (k == 7) begin
        chk("t6_o_valid", 32'(s_ov), 32'd1);
        chk("t6_o", 32'(s_o), 32'hAA);
      end
    end
`ifdef ARRAY_PACK_PARITY_EN
    step(1'b1, 1'b1, 2'b01, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b1, 2'b00, 1'b1);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    chk("t6_par_o", 32'(s_o), 32'h01);
    chk("t6_parity", 32'(s_par), 32'd1);
`endif

    // Random traffic with occasional resets and back-pressure.
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 3) != 0),
           IN_W'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
